// File: rtl/fir_sample_feeder.sv
// Test-pattern source for the FIR filter input: emits a programmed pattern of
// num_samples samples, flushes with FLUSH_LEN zeros, then pulses done.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | emitting pattern samples
// FLUSH | emitting FLUSH_LEN zero samples
// DONE  | one-cycle done pulse, then back to IDLE
module fir_sample_feeder #(
   parameter int          DW        = 8,
   parameter int          CW        = 8,
   parameter int          FLUSH_LEN = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic          hold,
   input  logic [2:0]    mode,
   input  logic [DW-1:0] amplitude,
   input  logic [CW-1:0] num_samples,
   output logic [DW-1:0] filter_in,
   output logic          sample_valid,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] sample_idx
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

   logic [1:0]    state;
   logic [2:0]    mode_q;
   logic [DW-1:0] amp_q;
   logic [CW-1:0] n_q;
   logic [FW-1:0] flush_cnt;
   logic [15:0]   lfsr;
   logic [CW-1:0] idx_inc;

   assign idx_inc = sample_idx + 1'b1;

   function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [DW-1:0] pat(input logic [2:0] m, input logic [DW-1:0] a,
                                         input logic [CW-1:0] i, input logic [15:0] lf);
      logic [DW-1:0] i_dw;
      i_dw = DW'(i);
      case (m)
         3'd0:    pat = (i == '0) ? a : '0;
         3'd1:    pat = a;
         3'd2:    pat = a + i_dw;
         3'd3:    pat = i[0] ? ('0 - a) : a;
         3'd4:    pat = lf[DW-1:0];
         default: pat = '0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         mode_q       <= '0;
         amp_q        <= '0;
         n_q          <= '0;
         flush_cnt    <= '0;
         lfsr         <= LFSR_SEED;
         filter_in    <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sample_idx   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               filter_in    <= '0;
               sample_valid <= 1'b0;
               busy         <= 1'b0;
               if (start) begin
                  sample_idx <= '0;
                  if (num_samples == '0) begin
                     done <= 1'b1;
                  end else begin
                     // Sample 0 goes out on the accepting edge itself.
                     mode_q       <= mode;
                     amp_q        <= amplitude;
                     n_q          <= num_samples;
                     filter_in    <= pat(mode, amplitude, '0, LFSR_SEED);
                     lfsr         <= lfsr_adv(LFSR_SEED);
                     sample_valid <= 1'b1;
                     busy         <= 1'b1;
                     sample_idx   <= CW'(1);
                     if (num_samples == CW'(1)) begin
                        state     <= S_FLUSH;
                        flush_cnt <= FLUSH_LAST;
                     end else begin
                        state <= S_RUN;
                     end
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  state        <= S_IDLE;
                  filter_in    <= '0;
                  sample_valid <= 1'b0;
                  busy         <= 1'b0;
               end else if (hold) begin
                  sample_valid <= 1'b0;
               end else begin
                  filter_in    <= pat(mode_q, amp_q, sample_idx, lfsr);
                  lfsr         <= lfsr_adv(lfsr);
                  sample_valid <= 1'b1;
                  sample_idx   <= idx_inc;
                  if (idx_inc == n_q) begin
                     state     <= S_FLUSH;
                     flush_cnt <= FLUSH_LAST;
                  end
               end
            end
            S_FLUSH: begin
               if (abort) begin
                  state        <= S_IDLE;
                  filter_in    <= '0;
                  sample_valid <= 1'b0;
                  busy         <= 1'b0;
               end else if (hold) begin
                  sample_valid <= 1'b0;
               end else begin
                  filter_in    <= '0;
                  sample_valid <= 1'b1;
                  if (flush_cnt == '0) begin
                     state <= S_DONE;
                  end else begin
                     flush_cnt <= flush_cnt - 1'b1;
                  end
               end
            end
            default: begin
               filter_in    <= '0;
               sample_valid <= 1'b0;
               busy         <= 1'b0;
               done         <= 1'b1;
               state        <= S_IDLE;
            end
         endcase
      end
   end

endmodule
